// File: rtl/sequence_pkg.sv
// Shared encodings for the integer-sequence engine: run modes, FSM states
// and the three seed terms each mode loads into the window.
package sequence_pkg;

    typedef logic [1:0] seq_mode_t;
    typedef logic [1:0] seq_state_t;

    localparam seq_mode_t MODE_FIB      = 2'b00;
    localparam seq_mode_t MODE_PADOVAN  = 2'b01;
    localparam seq_mode_t MODE_PERRIN   = 2'b10;
    localparam seq_mode_t MODE_RESERVED = 2'b11;

    localparam seq_state_t ST_IDLE = 2'd0;
    localparam seq_state_t ST_LOAD = 2'd1;
    localparam seq_state_t ST_RUN  = 2'd2;
    localparam seq_state_t ST_DONE = 2'd3;

    // Seeds packed two bits per term, term 0 in the least significant slot.
    localparam logic [5:0] SEEDS_FIB     = {2'd1, 2'd1, 2'd0};
    localparam logic [5:0] SEEDS_PADOVAN = {2'd1, 2'd1, 2'd1};
    localparam logic [5:0] SEEDS_PERRIN  = {2'd2, 2'd0, 2'd3};

    function automatic logic [1:0] seedTerm(input seq_mode_t selMode, input logic [1:0] pos);
        logic [5:0] seeds;
        case (selMode)
            MODE_FIB:     seeds = SEEDS_FIB;
            MODE_PADOVAN: seeds = SEEDS_PADOVAN;
            MODE_PERRIN:  seeds = SEEDS_PERRIN;
            default:      seeds = 6'd0;
        endcase
        return seeds[{pos, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/seq_window.sv
// Three-term sliding window with per-term overflow bits and the
// mode-selected adder that produces the next term.
module seq_window
    import sequence_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstN,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [1:0]           i_mode,
    output logic [DATAWIDTH-1:0] o_r0Data,
    output logic                 o_r0Ovf,
    output logic                 o_r1Ovf
);

    logic [DATAWIDTH-1:0] r_data0, r_data1, r_data2;
    logic                 r_ovf0, r_ovf1, r_ovf2;

    logic [DATAWIDTH-1:0] w_addA, w_addB;
    logic                 w_addAOvf, w_addBOvf;
    logic [DATAWIDTH:0]   w_sum;
    logic                 w_nextOvf;

    // Fibonacci sums the two newest terms; Padovan and Perrin skip the newest.
    always_comb begin
        w_addA    = r_data0;
        w_addB    = r_data1;
        w_addAOvf = r_ovf0;
        w_addBOvf = r_ovf1;
        if (i_mode == MODE_FIB) begin
            w_addA    = r_data1;
            w_addB    = r_data2;
            w_addAOvf = r_ovf1;
            w_addBOvf = r_ovf2;
        end
        w_sum     = {1'b0, w_addA} + {1'b0, w_addB};
        w_nextOvf = w_sum[DATAWIDTH] | w_addAOvf | w_addBOvf;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_ovf0  <= 1'b0;
            r_ovf1  <= 1'b0;
            r_ovf2  <= 1'b0;
        end else if (i_load) begin
            r_data0 <= DATAWIDTH'(seedTerm(i_mode, 2'd0));
            r_data1 <= DATAWIDTH'(seedTerm(i_mode, 2'd1));
            r_data2 <= DATAWIDTH'(seedTerm(i_mode, 2'd2));
            r_ovf0  <= 1'b0;
            r_ovf1  <= 1'b0;
            r_ovf2  <= 1'b0;
        end else if (i_shift) begin
            r_data0 <= r_data1;
            r_data1 <= r_data2;
            r_data2 <= w_sum[DATAWIDTH-1:0];
            r_ovf0  <= r_ovf1;
            r_ovf1  <= r_ovf2;
            r_ovf2  <= w_nextOvf;
        end
    end

    assign o_r0Data = r_data0;
    assign o_r0Ovf  = r_ovf0;
    assign o_r1Ovf  = r_ovf1;

endmodule

// File: rtl/sequence_engine.sv
// Fibonacci / Padovan / Perrin term streamer with start/busy/done handshake
// and a sticky overflow flag that terminates a run early.
module sequence_engine
    import sequence_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int COUNTWIDTH = 8
) (
    input  logic                  Clk_System,
    input  logic                  lowRst_System,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [COUNTWIDTH-1:0] nTerms,
    output logic                  busy,
    output logic                  termValid,
    output logic [DATAWIDTH-1:0]  termData,
    output logic [COUNTWIDTH-1:0] termIndex,
    output logic                  done,
    output logic                  overflow
);

    seq_state_t            r_state;
    logic [1:0]            r_mode;
    logic [COUNTWIDTH-1:0] r_count;
    logic [COUNTWIDTH-1:0] r_index;
    logic                  r_busy, r_termValid, r_done, r_overflow;

    seq_state_t            w_nextState;
    logic                  w_accept;
    logic                  w_load, w_shift;
    logic                  w_r0Ovf, w_r1Ovf, w_nextR0Ovf;
    logic [COUNTWIDTH-1:0] w_lastIndex;
    logic [DATAWIDTH-1:0]  w_r0Data;

    seq_window #(
        .DATAWIDTH(DATAWIDTH)
    ) u_window (
        .i_clk   (Clk_System),
        .i_rstN  (lowRst_System),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_mode  (r_mode),
        .o_r0Data(w_r0Data),
        .o_r0Ovf (w_r0Ovf),
        .o_r1Ovf (w_r1Ovf)
    );

    assign w_load      = (r_state == ST_LOAD);
    assign w_shift     = (r_state == ST_RUN);
    assign w_lastIndex = r_count - COUNTWIDTH'(1);
    // The term shown next cycle is r1 after a shift, or a fresh seed after LOAD.
    assign w_nextR0Ovf = (r_state == ST_RUN) & w_r1Ovf;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = (mode == MODE_RESERVED) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: w_nextState = (r_count == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (w_r0Ovf || (r_index == w_lastIndex)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clk_System) begin
        if (!lowRst_System) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_FIB;
            r_count     <= '0;
            r_index     <= '0;
            r_busy      <= 1'b0;
            r_termValid <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_busy      <= (w_nextState == ST_LOAD) || (w_nextState == ST_RUN);
            r_termValid <= (w_nextState == ST_RUN) && !w_nextR0Ovf;
            r_done      <= (w_nextState == ST_DONE);
            if (w_accept) begin
                r_mode  <= mode;
                r_count <= nTerms;
            end
            if (w_load) begin
                r_index <= '0;
            end else if (w_shift) begin
                r_index <= r_index + COUNTWIDTH'(1);
            end
            if (w_accept) begin
                r_overflow <= 1'b0;
            end else if (w_shift && w_r0Ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign termValid = r_termValid;
    assign termData  = w_r0Data;
    assign termIndex = r_index;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule
